// File: rtl/audio_nios_ocimem_arbiter_if.sv
// Bus bundle between debug-slave JTAG strobes, local master and OCI RAM.
// slave = arbiter side, master = environment side (host, requester, RAM).
interface audio_nios_ocimem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic [37:0]       jdo;
  logic              take_action_ocimem_a;
  logic              take_action_ocimem_b;
  logic              take_no_action_ocimem_a;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;
  logic              loc_req;
  logic              loc_we;
  logic [ADDR_W-1:0] loc_addr;
  logic [31:0]       loc_wdata;
  logic              loc_ack;
  logic [31:0]       loc_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  jdo, take_action_ocimem_a, take_action_ocimem_b,
    input  take_no_action_ocimem_a,
    output MonDReg, monitor_ready, monitor_error,
    input  loc_req, loc_we, loc_addr, loc_wdata,
    output loc_ack, loc_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output jdo, take_action_ocimem_a, take_action_ocimem_b,
    output take_no_action_ocimem_a,
    input  MonDReg, monitor_ready, monitor_error,
    output loc_req, loc_we, loc_addr, loc_wdata,
    input  loc_ack, loc_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/audio_nios_ocimem_arbiter.sv
// OCI RAM arbiter: JTAG debug slot vs local requester, 3-cycle access FSM.
// AUDIO_OCIMEM_ARB_JTAG_PRIO_EN: strict JTAG priority instead of round-robin.
module audio_nios_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input logic                         clk,
  input logic                         reset_n,
  audio_nios_ocimem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_e;
  typedef enum logic {OWN_LOC, OWN_JTAG} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              slot_vld_q, slot_vld_d;
  logic              slot_we_q, slot_we_d;
  logic [31:0]       slot_wdata_q, slot_wdata_d;
  logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
  logic              mon_err_q, mon_err_d;
  logic [31:0]       mon_q, mon_d;
  logic [31:0]       loc_rdata_q, loc_rdata_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;
  logic              overrun;
  logic              grant_jtag;
  logic              loc_capt;
  logic              unused_jdo;

  assign unused_jdo = ^{bus.jdo[37:36], bus.jdo[1:0]};

  // _a and _b together: _a runs, _b counts as an overrun
  assign overrun = (slot_vld_q & (bus.take_action_ocimem_a
                                | bus.take_action_ocimem_b))
                 | (bus.take_action_ocimem_a & bus.take_action_ocimem_b);

`ifdef AUDIO_OCIMEM_ARB_JTAG_PRIO_EN
  assign grant_jtag = slot_vld_q;
`else
  // owner_q doubles as last_owner: on conflict grant the other side
  assign grant_jtag = slot_vld_q & (~bus.loc_req | (owner_q == OWN_LOC));
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    slot_vld_d   = slot_vld_q;
    slot_we_d    = slot_we_q;
    slot_wdata_d = slot_wdata_q;
    jtag_addr_d  = jtag_addr_q;
    mon_err_d    = mon_err_q;
    mon_d        = mon_q;
    loc_rdata_d  = loc_rdata_q;
    ram_en_d     = 1'b0;
    ram_we_d     = ram_we_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_jtag) begin
          state_d     = ISSUE;
          owner_d     = OWN_JTAG;
          ram_en_d    = 1'b1;
          ram_we_d    = slot_we_q;
          ram_addr_d  = jtag_addr_q;
          ram_wdata_d = slot_wdata_q;
          slot_vld_d  = 1'b0;
          jtag_addr_d = jtag_addr_q + ADDR_W'(1);
        end else if (bus.loc_req) begin
          state_d     = ISSUE;
          owner_d     = OWN_LOC;
          ram_en_d    = 1'b1;
          ram_we_d    = bus.loc_we;
          ram_addr_d  = bus.loc_addr;
          ram_wdata_d = bus.loc_wdata;
        end
      end
      ISSUE: state_d = CAPT;
      CAPT: begin
        state_d = IDLE;
        if (!ram_we_q) begin
          if (owner_q == OWN_JTAG) mon_d = bus.ram_rdata;
          else                     loc_rdata_d = bus.ram_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
    // slot load is exclusive with a JTAG grant (that needs slot valid)
    if (!slot_vld_q && bus.take_action_ocimem_a) begin
      jtag_addr_d = bus.jdo[ADDR_W+1:2];
      if (bus.jdo[35]) begin
        slot_vld_d = 1'b1;
        slot_we_d  = 1'b0;
      end
    end else if (!slot_vld_q && bus.take_action_ocimem_b) begin
      slot_vld_d   = 1'b1;
      slot_we_d    = bus.jdo[35];
      slot_wdata_d = bus.jdo[34:3];
    end
    if (overrun)                          mon_err_d = 1'b1;
    else if (bus.take_no_action_ocimem_a) mon_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_LOC;
      slot_vld_q   <= 1'b0;
      slot_we_q    <= 1'b0;
      slot_wdata_q <= '0;
      jtag_addr_q  <= '0;
      mon_err_q    <= 1'b0;
      mon_q        <= '0;
      loc_rdata_q  <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      slot_vld_q   <= slot_vld_d;
      slot_we_q    <= slot_we_d;
      slot_wdata_q <= slot_wdata_d;
      jtag_addr_q  <= jtag_addr_d;
      mon_err_q    <= mon_err_d;
      mon_q        <= mon_d;
      loc_rdata_q  <= loc_rdata_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign loc_capt          = (state_q == CAPT) & (owner_q == OWN_LOC);
  assign bus.loc_ack       = loc_capt;
  assign bus.loc_rdata     = (loc_capt & ~ram_we_q) ? bus.ram_rdata
                                                    : loc_rdata_q;
  assign bus.MonDReg       = mon_q;
  assign bus.monitor_error = mon_err_q;
  assign bus.monitor_ready = ~slot_vld_q
                           & ~((state_q != IDLE) & (owner_q == OWN_JTAG));
  assign bus.ram_en        = ram_en_q;
  assign bus.ram_we        = ram_we_q;
  assign bus.ram_addr      = ram_addr_q;
  assign bus.ram_wdata     = ram_wdata_q;
endmodule

// File: tb/tb_audio_nios_ocimem_arbiter.sv
// Directed + random bench for audio_nios_ocimem_arbiter.
// Bench plays JTAG host, local master and a 1-cycle-latency RAM.
`define CK(t, o, e) check(t, 64'(o), 64'(e))

module tb_audio_nios_ocimem_arbiter;
  localparam int AW = 8;
`ifdef AUDIO_OCIMEM_ARB_JTAG_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  audio_nios_ocimem_arbiter_if #(.ADDR_W(AW)) bus ();
  audio_nios_ocimem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  logic [31:0]   mem [256];
  int            en_cnt = 0;
  int            ack_cnt = 0;
  int            b2b_cnt = 0;
  logic          prev_en = 1'b0;
  logic [AW-1:0] last_addr = '0;

  always @(posedge clk) begin
    prev_en <= bus.ram_en;
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      bus.ram_rdata <= mem[bus.ram_addr];
      en_cnt    <= en_cnt + 1;
      last_addr <= bus.ram_addr;
      if (prev_en) b2b_cnt <= b2b_cnt + 1;
    end
    if (bus.loc_ack) ack_cnt <= ack_cnt + 1;
  end

  // reference model state
  logic [31:0]   ref_mem [256];
  logic [AW-1:0] jaddr;
  logic [31:0]   exp_mon;
  logic [31:0]   exp_lrd;
  bit            last_j;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jd_a(input logic [AW-1:0] a, input bit rd);
    logic [37:0] d;
    d = '0;
    d[35] = rd;
    d[AW+1:2] = a;
    return d;
  endfunction

  function automatic logic [37:0] jd_b(input bit we, input logic [31:0] w);
    logic [37:0] d;
    d = '0;
    d[35] = we;
    d[34:3] = w;
    return d;
  endfunction

  task automatic jstrobe(input bit a, input bit b, input bit clr,
                         input logic [37:0] d);
    bus.jdo = d;
    bus.take_action_ocimem_a = a;
    bus.take_action_ocimem_b = b;
    bus.take_no_action_ocimem_a = clr;
    tick();
    bus.take_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bus.monitor_ready && n < 20) begin
      tick();
      n++;
    end
    `CK(tag, n < 20, 1'b1);
  endtask

  task automatic wait_ack(input int start, output int at,
                          output logic [31:0] rd);
    int c;
    c = start;
    at = -1;
    rd = '0;
    while (at < 0 && c < start + 14) begin
      tick();
      c++;
      if (bus.loc_ack) begin
        at = c;
        rd = bus.loc_rdata;
        bus.loc_req = 1'b0;
      end
    end
    bus.loc_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.loc_req = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    jaddr = '0;
    exp_mon = '0;
    last_j = 1'b0;
  endtask

  task automatic model_j(input int kind, input logic [AW-1:0] a,
                         input logic [31:0] wd);
    logic [AW-1:0] ad;
    ad = (kind == 0) ? a : jaddr;
    jaddr = ad + 1'b1;
    if (kind == 1) ref_mem[ad] = wd;
    else           exp_mon = ref_mem[ad];
  endtask

  task automatic model_l(input bit we, input logic [AW-1:0] a,
                         input logic [31:0] wd);
    if (we) ref_mem[a] = wd;
    else    exp_lrd = ref_mem[a];
  endtask

  initial begin
    int at;
    int e0;
    int a0;
    int mism;
    logic [31:0] rd;
    logic [31:0] v;
    reset_n = 1'b0;
    bus.jdo = '0;
    bus.take_action_ocimem_a = 1'b0;
    bus.take_action_ocimem_b = 1'b0;
    bus.take_no_action_ocimem_a = 1'b0;
    bus.loc_req = 1'b0;
    bus.loc_we = 1'b0;
    bus.loc_addr = '0;
    bus.loc_wdata = '0;
    bus.ram_rdata <= '0;
    for (int i = 0; i < 256; i++) begin
      v = (i == 16) ? 32'hDEADBEEF : $urandom;
      mem[i] <= v;
      ref_mem[i] = v;
    end
    jaddr = '0;
    exp_mon = '0;
    exp_lrd = '0;
    last_j = 1'b0;
    tick();
    tick();
    `CK("rst_mon", bus.MonDReg, 32'h0);
    `CK("rst_ready", bus.monitor_ready, 1'b1);
    `CK("rst_err", bus.monitor_error, 1'b0);
    `CK("rst_ack", bus.loc_ack, 1'b0);
    `CK("rst_lrd", bus.loc_rdata, 32'h0);
    `CK("rst_en", bus.ram_en, 1'b0);
    `CK("rst_we", bus.ram_we, 1'b0);
    `CK("rst_addr", bus.ram_addr, 8'h0);
    `CK("rst_wdata", bus.ram_wdata, 32'h0);
    reset_n = 1'b1;
    tick();

    // JTAG read via _a, cycle-exact
    jstrobe(1'b1, 1'b0, 1'b0, jd_a(8'h10, 1'b1));
    `CK("t1_c1_ready", bus.monitor_ready, 1'b0);
    `CK("t1_c1_en", bus.ram_en, 1'b0);
    tick();
    `CK("t1_c2_en", bus.ram_en, 1'b1);
    `CK("t1_c2_addr", bus.ram_addr, 8'h10);
    `CK("t1_c2_we", bus.ram_we, 1'b0);
    tick();
    `CK("t1_c3_en", bus.ram_en, 1'b0);
    `CK("t1_c3_ready", bus.monitor_ready, 1'b0);
    tick();
    `CK("t1_c4_mon", bus.MonDReg, 32'hDEADBEEF);
    `CK("t1_c4_ready", bus.monitor_ready, 1'b1);
    jaddr = 8'h11;
    exp_mon = 32'hDEADBEEF;

    // address increment, wrap, write keeps MonDReg
    jstrobe(1'b0, 1'b1, 1'b0, jd_b(1'b0, 32'h0));
    wait_ready("t2_rd_done");
    `CK("t2_incr_addr", last_addr, 8'h11);
    exp_mon = ref_mem[8'h11];
    `CK("t2_rd_mon", bus.MonDReg, exp_mon);
    e0 = en_cnt;
    jstrobe(1'b1, 1'b0, 1'b0, jd_a(8'hFF, 1'b0));
    tick();
    tick();
    `CK("t2_aonly_noacc", en_cnt - e0, 0);
    jstrobe(1'b0, 1'b1, 1'b0, jd_b(1'b1, 32'h12345678));
    wait_ready("t2_wr_done");
    ref_mem[8'hFF] = 32'h12345678;
    `CK("t2_wr_addr", last_addr, 8'hFF);
    `CK("t2_wr_mem", mem[8'hFF], 32'h12345678);
    `CK("t2_mon_keep", bus.MonDReg, exp_mon);
    jstrobe(1'b0, 1'b1, 1'b0, jd_b(1'b0, 32'h0));
    wait_ready("t2_wrap_done");
    `CK("t2_wrap_addr", last_addr, 8'h00);
    exp_mon = ref_mem[0];
    `CK("t2_wrap_mon", bus.MonDReg, exp_mon);
    jaddr = 8'h01;

    // overrun handling
    e0 = en_cnt;
    jstrobe(1'b0, 1'b1, 1'b0, jd_b(1'b0, 32'h0));
    jstrobe(1'b0, 1'b1, 1'b0, jd_b(1'b0, 32'h0));
    wait_ready("t3_done");
    `CK("t3_one_acc", en_cnt - e0, 1);
    `CK("t3_err", bus.monitor_error, 1'b1);
    exp_mon = ref_mem[1];
    `CK("t3_mon", bus.MonDReg, exp_mon);
    tick();
    tick();
    `CK("t3_err_sticky", bus.monitor_error, 1'b1);
    jstrobe(1'b0, 1'b0, 1'b1, '0);
    `CK("t3_err_clr", bus.monitor_error, 1'b0);
    e0 = en_cnt;
    jstrobe(1'b1, 1'b1, 1'b1, jd_a(8'h05, 1'b1));
    wait_ready("t3_ab_done");
    `CK("t3_ab_acc", en_cnt - e0, 1);
    `CK("t3_ab_addr", last_addr, 8'h05);
    `CK("t3_ab_err", bus.monitor_error, 1'b1);
    exp_mon = ref_mem[5];
    `CK("t3_ab_mon", bus.MonDReg, exp_mon);
    jstrobe(1'b0, 1'b0, 1'b1, '0);
    `CK("t3_ab_clr", bus.monitor_error, 1'b0);

    // first conflict after reset goes to JTAG
    do_reset();
    jstrobe(1'b1, 1'b0, 1'b0, jd_a(8'h30, 1'b1));
    bus.loc_req = 1'b1;
    bus.loc_we = 1'b0;
    bus.loc_addr = 8'h20;
    bus.loc_wdata = '0;
    tick();
    `CK("t4_c2_en", bus.ram_en, 1'b1);
    `CK("t4_jfirst_addr", bus.ram_addr, 8'h30);
    `CK("t4_c2_ack", bus.loc_ack, 1'b0);
    wait_ack(2, at, rd);
    `CK("t4_ack_cyc", at, 6);
    `CK("t4_lrd", rd, ref_mem[8'h20]);
    wait_ready("t4_done");
    tick();
    exp_mon = ref_mem[8'h30];
    `CK("t4_mon", bus.MonDReg, exp_mon);
    `CK("t4_lrd_hold", bus.loc_rdata, ref_mem[8'h20]);

    // second conflict: local (round-robin) or JTAG again (priority)
    jstrobe(1'b1, 1'b0, 1'b0, jd_a(8'h40, 1'b1));
    bus.loc_req = 1'b1;
    bus.loc_addr = 8'h21;
    tick();
    bus.jdo = jd_b(1'b0, 32'h0);
    bus.take_action_ocimem_b = 1'b1;
    tick();
    bus.take_action_ocimem_b = 1'b0;
    wait_ack(3, at, rd);
    `CK("t5_ack_cyc", at, PRIO ? 9 : 6);
    `CK("t5_lrd", rd, ref_mem[8'h21]);
    wait_ready("t5_done");
    tick();
    exp_mon = ref_mem[8'h41];
    `CK("t5_mon", bus.MonDReg, exp_mon);
    jaddr = 8'h42;
    last_j = !PRIO;

    // random mix against the transaction-level model
    for (int it = 0; it < 40; it++) begin
      int kj;
      int kl;
      int exp_ack;
      bit hasj;
      bit hasl;
      bit jfirst;
      bit lwe;
      logic [AW-1:0] aa;
      logic [AW-1:0] la;
      logic [31:0] wd;
      logic [31:0] lwd;
      kj = $urandom_range(0, 3);
      kl = $urandom_range(0, 2);
      if (kj == 3 && kl == 2) kl = 0;
      hasj = (kj != 3);
      hasl = (kl != 2);
      lwe = (kl == 1);
      aa = AW'($urandom_range(0, 7));
      la = AW'($urandom_range(0, 7));
      wd = $urandom;
      lwd = $urandom;
      jfirst = hasj && (!hasl || PRIO || !last_j);
      if (hasj && jfirst) model_j(kj, aa, wd);
      if (hasl) model_l(lwe, la, lwd);
      if (hasj && !jfirst) model_j(kj, aa, wd);
      last_j = hasj && (!hasl || !jfirst);
      exp_ack = (hasj && jfirst) ? 6 : 3;
      case (kj)
        0: jstrobe(1'b1, 1'b0, 1'b0, jd_a(aa, 1'b1));
        1: jstrobe(1'b0, 1'b1, 1'b0, jd_b(1'b1, wd));
        2: jstrobe(1'b0, 1'b1, 1'b0, jd_b(1'b0, wd));
        default: tick();
      endcase
      if (hasl) begin
        bus.loc_req = 1'b1;
        bus.loc_we = lwe;
        bus.loc_addr = la;
        bus.loc_wdata = lwd;
        wait_ack(1, at, rd);
        `CK("rnd_ack_cyc", at, exp_ack);
        if (!lwe) `CK("rnd_lrd", rd, exp_lrd);
      end
      wait_ready("rnd_ready");
      tick();
      `CK("rnd_mon", bus.MonDReg, exp_mon);
    end

    // reset during ISSUE aborts local access and discards the slot
    bus.loc_req = 1'b1;
    bus.loc_we = 1'b0;
    bus.loc_addr = 8'h03;
    bus.jdo = jd_b(1'b0, 32'h0);
    bus.take_action_ocimem_b = 1'b1;
    tick();
    bus.take_action_ocimem_b = 1'b0;
    `CK("rst_mid_en", bus.ram_en, 1'b1);
    `CK("rst_mid_slot", bus.monitor_ready, 1'b0);
    a0 = ack_cnt;
    reset_n = 1'b0;
    #1;
    bus.loc_req = 1'b0;
    `CK("rst_mid_ack", bus.loc_ack, 1'b0);
    `CK("rst_mid_en0", bus.ram_en, 1'b0);
    `CK("rst_mid_ready", bus.monitor_ready, 1'b1);
    `CK("rst_mid_mon", bus.MonDReg, 32'h0);
    `CK("rst_mid_lrd", bus.loc_rdata, 32'h0);
    `CK("rst_mid_addr", bus.ram_addr, 8'h0);
    tick();
    tick();
    reset_n = 1'b1;
    e0 = en_cnt;
    repeat (4) tick();
    `CK("rst_mid_noack", ack_cnt - a0, 0);
    `CK("rst_mid_noacc", en_cnt - e0, 0);

    mism = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) mism++;
    `CK("ram_contents", mism, 0);
    `CK("no_b2b_en", b2b_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/audio_nios_ocimem_arbiter.md
# audio_nios_ocimem_arbiter

Arbitrates single-port on-chip debug memory (OCI RAM) between the JTAG debug host and a local requester (trace-dump / self-test master). JTAG commands arrive as `take_action_ocimem_*` strobes with the 38-bit `jdo` word from the debug slave sysclk stage. The block sequences each access through a fixed 3-state FSM, returns read data on `MonDReg`/`loc_rdata`, and reports host overruns on `monitor_error`. It sits in the `clk` domain between the debug slave wrapper and the OCI RAM.

## Interface
- `ADDR_W`, 8, RAM word-address width (1..30)
- `clk`  in  1  system clock, all logic rising-edge
- `reset_n`  in  1  asynchronous active-low reset
- `jdo`  in  38  JTAG data word; valid with take_action strobes
- `take_action_ocimem_a`  in  1  load `jtag_addr <= jdo[ADDR_W+1:2]`; if `jdo[35]`=1 also queue read
- `take_action_ocimem_b`  in  1  queue access at `jtag_addr`; `jdo[35]`=1 write `jdo[34:3]`, 0 read
- `take_no_action_ocimem_a`  in  1  clear sticky `monitor_error`
- `MonDReg`  out  32  last JTAG read data
- `monitor_ready`  out  1  JTAG slot empty and no JTAG access in flight
- `monitor_error`  out  1  sticky JTAG command overrun
- `loc_req`  in  1  local request, level, held until `loc_ack`
- `loc_we`  in  1  local write enable
- `loc_addr`  in  ADDR_W  local word address
- `loc_wdata`  in  32  local write data
- `loc_ack`  out  1  one-cycle completion pulse
- `loc_rdata`  out  32  local read data, valid with `loc_ack`, held until next local read
- `ram_en`, `ram_we`  out  1 each  RAM strobes, registered
- `ram_addr`  out  ADDR_W  RAM address, registered
- `ram_wdata`  out  32  RAM write data, registered
- `ram_rdata`  in  32  RAM read data, 1-cycle latency after `ram_en`

## Operation
- JTAG slot: one entry {valid, we, wdata}. A take_action strobe loads it. Strobe while slot valid -> command dropped, `monitor_error`<=1. `_a` and `_b` same cycle -> `_a` executed, `_b` dropped as overrun.
- `take_no_action_ocimem_a` clears `monitor_error`; a simultaneous overrun wins (error stays 1).
- FSM IDLE -> ISSUE -> CAPT -> IDLE. IDLE: if slot valid or `loc_req`, choose winner, register `ram_*`, clear slot if JTAG. ISSUE: `ram_en`=1 exactly one cycle. CAPT: `ram_en`=0; on read capture `ram_rdata` into `MonDReg` (JTAG) or `loc_rdata` (local); pulse `loc_ack` if local (read or write).
- Each issued JTAG access increments `jtag_addr` modulo 2^ADDR_W (255 -> 0 for ADDR_W=8). JTAG writes leave `MonDReg` unchanged.
- Arbitration: round-robin on conflict, grant the requester not granted last; `last_owner` resets to LOCAL, so JTAG wins the first conflict.
- `loc_req` still high in the IDLE after `loc_ack` is a new request.
- `monitor_ready` = ~slot_valid & ~(FSM≠IDLE & owner=JTAG).
- Reset values: `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0, `loc_ack`=0, `loc_rdata`=0, all `ram_*`=0, `jtag_addr`=0, FSM IDLE, slot empty. Reset mid-access aborts: no ack, slot discarded.

## Timing
- Strobe at cycle 0 -> slot valid cycle 1 (IDLE arbitrates) -> `ram_en` cycle 2 -> capture/`loc_ack` cycle 3 -> `MonDReg` new value and `monitor_ready`=1 from cycle 4.
- Local: `loc_req` seen in IDLE at cycle n -> `loc_ack` at n+2.
- Throughput: one access per 3 cycles; no back-to-back `ram_en`.
- `loc_addr`/`loc_we`/`loc_wdata` stable from request until `loc_ack`.

## Configuration
- `AUDIO_OCIMEM_ARB_JTAG_PRIO_EN`: defined -> JTAG has strict priority; local granted only when slot empty; `last_owner` unused. Undefined -> round-robin as above.

## Test plan
- Reset then `_a` with `jdo[9:2]`=0x10, `jdo[35]`=1, RAM[0x10]=0xDEADBEEF -> `ram_en` cycle 2 addr 0x10, `MonDReg`=0xDEADBEEF cycle 4, `jtag_addr`=0x11.
- `_b` write 0x12345678 at addr 0xFF -> RAM[0xFF] written, `jtag_addr` wraps to 0x00, `MonDReg` unchanged.
- Two `_b` strobes cycles 0 and 1 -> second dropped, `monitor_error`=1 until `take_no_action_ocimem_a`; one RAM access only.
- `loc_req` read addr 0x20 and JTAG slot valid same IDLE -> JTAG first (reset `last_owner`=LOCAL), local `loc_ack` 3 cycles later with `loc_rdata`=RAM[0x20]; with `_JTAG_PRIO_EN` repeated JTAG strobes starve local.
- `reset_n` low during ISSUE -> no `loc_ack`, all outputs reset values, `monitor_ready`=1.
